// File: rtl/arm_fetch_pkg.sv
// ============================================================================
// arm_fetch_pkg : shared types and constants for the instruction-fetch block
// Revision 1.0
// ============================================================================
`default_nettype none

package arm_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_controller_fetch_queue.sv
// ============================================================================
// fetch_queue : DEPTH-entry prefetch FIFO with synchronous flush and count
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     entry_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/ifetch_controller.sv
// ============================================================================
// ifetch_controller : fetch PC sequencer, imem handshake, branch flush logic
// Optional statistics counters enabled by defining IFETCH_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module ifetch_controller
    import arm_fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_adr,
    input  logic              imem_rdy,
    input  logic [INST_W-1:0] imem_inst,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
`ifdef IFETCH_STATS_EN
    output logic [31:0]       stat_fetch_cnt,
    output logic [31:0]       stat_drop_cnt,
`endif
    output logic [ADDR_W-1:0] if_pc
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic [CNT_W-1:0]  q_count;
    logic              q_valid;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic              hs;
    fetch_entry_t      q_entry;
    fetch_entry_t      q_head;

    // pc_q is the address on the bus; during FLUSH it still holds the
    // abandoned request while tgt_q carries the redirect target.
    assign imem_req     = (state_q == FLUSH) || (q_count < FULL_CNT);
    assign imem_adr     = pc_q;
    assign hs           = imem_req && imem_rdy;
    assign q_pop        = q_valid && !freeze && !branch_taken;
    assign q_entry.pc   = pc_q + PC_STEP;
    assign q_entry.inst = imem_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        q_push  = 1'b0;
        q_flush = 1'b0;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    q_flush = 1'b1;
                    if (imem_req && !imem_rdy) begin
                        state_d = FLUSH;
                        tgt_d   = branch_addr;
                    end else begin
                        pc_d = branch_addr;
                    end
                end else if (hs) begin
                    q_push = 1'b1;
                    pc_d   = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    q_flush = 1'b1;
                    tgt_d   = branch_addr;
                end
                if (imem_rdy) begin
                    state_d = FETCH;
                    pc_d    = branch_taken ? branch_addr : tgt_q;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (q_flush),
        .push_i  (q_push),
        .entry_i (q_entry),
        .pop_i   (q_pop),
        .count_o (q_count),
        .valid_o (q_valid),
        .head_o  (q_head)
    );

    assign if_valid = q_valid;
    assign if_inst  = q_valid ? q_head.inst : '0;
    assign if_pc    = q_valid ? q_head.pc   : '0;

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        drop;
    logic [31:0] discard;

    // A completed handshake is dropped whenever it lands in FLUSH or
    // coincides with a redirect; live queue entries are discarded on redirect.
    assign drop    = hs && ((state_q == FLUSH) || branch_taken);
    assign discard = branch_taken ? 32'(q_count) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(hs);
            drop_cnt_q  <= drop_cnt_q + 32'(drop) + discard;
        end
    end

    assign stat_fetch_cnt = fetch_cnt_q;
    assign stat_drop_cnt  = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_controller.sv
// ============================================================================
// tb_ifetch_controller : randomized and directed bench with a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ifetch_controller;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        freeze       = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr  = 32'h0;
    logic        imem_rdy     = 1'b0;
    logic        imem_req;
    logic [31:0] imem_adr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_inst = mem_word(imem_adr);

    ifetch_controller #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req       (imem_req),
        .imem_adr       (imem_adr),
        .imem_rdy       (imem_rdy),
        .imem_inst      (imem_inst),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
`ifdef IFETCH_STATS_EN
        .stat_fetch_cnt (stat_fetch_cnt),
        .stat_drop_cnt  (stat_drop_cnt),
`endif
        .if_pc          (if_pc)
    );

    // Reference model: buffered {pc+4, inst} pairs, the address on the bus,
    // and whether the bus response is to be thrown away.
    logic [63:0] mq[$];
    logic [31:0] m_adr;
    logic [31:0] m_tgt;
    bit          m_flush;
    logic [31:0] m_fetch;
    logic [31:0] m_drop;

    function automatic void model_reset();
        mq.delete();
        m_adr   = RESET_PC;
        m_tgt   = RESET_PC;
        m_flush = 1'b0;
        m_fetch = 32'd0;
        m_drop  = 32'd0;
    endfunction

    function automatic logic [97:0] model_out();
        logic [63:0] h;
        bit          v;
        bit          req;
        v   = (mq.size() > 0);
        h   = 64'd0;
        if (v) h = mq[0];
        req = m_flush || (mq.size() < DEPTH);
        return {req, m_adr, v, h};
    endfunction

    function automatic void model_step(input bit frz, input bit br,
                                       input logic [31:0] bad, input bit rdy);
        bit req;
        bit hs;
        req = m_flush || (mq.size() < DEPTH);
        hs  = req && rdy;
        if (hs) m_fetch = m_fetch + 32'd1;
        if (br) begin
            m_drop = m_drop + 32'(mq.size()) + (hs ? 32'd1 : 32'd0);
            mq.delete();
            if (m_flush) begin
                if (rdy) begin
                    m_flush = 1'b0;
                    m_adr   = bad;
                end else begin
                    m_tgt = bad;
                end
            end else if (req && !rdy) begin
                m_flush = 1'b1;
                m_tgt   = bad;
            end else begin
                m_adr = bad;
            end
        end else if (m_flush) begin
            if (rdy) begin
                m_drop  = m_drop + 32'd1;
                m_flush = 1'b0;
                m_adr   = m_tgt;
            end
        end else begin
            if (mq.size() > 0 && !frz) void'(mq.pop_front());
            if (hs) begin
                mq.push_back({m_adr + 32'd4, mem_word(m_adr)});
                m_adr = m_adr + 32'd4;
            end
        end
    endfunction

    task automatic cycle(input bit frz, input bit br, input logic [31:0] bad, input bit rdy);
        freeze       = frz;
        branch_taken = br;
        branch_addr  = bad;
        imem_rdy     = rdy;
        @(posedge clk);
        model_step(frz, br, bad, rdy);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        imem_rdy     = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({imem_req, imem_adr, if_valid, if_pc, if_inst} !== {1'b1, RESET_PC, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got req=%b adr=%h v=%b pc=%h inst=%h, expected req=1 adr=%h v=0 pc=0 inst=0",
                     imem_req, imem_adr, if_valid, if_pc, if_inst, RESET_PC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({imem_adr, if_valid, if_pc, if_inst} !== {32'(4*k), 1'b1, 32'(4*k), mem_word(32'(4*k-4))}) begin
                errors++;
                $display("FAIL stream k=%0d: got adr=%h v=%b pc=%h inst=%h, expected adr=%h v=1 pc=%h",
                         k, imem_adr, if_valid, if_pc, if_inst, 32'(4*k), 32'(4*k));
            end
        end
    endtask

    task automatic test_slow_rdy();
        logic        prev_req;
        logic [31:0] prev_adr;
        bit          rdy;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            prev_req = imem_req;
            prev_adr = imem_adr;
            rdy      = ((i % 3) == 2);
            cycle(1'b0, 1'b0, 32'h0, rdy);
            checks++;
            if ({imem_req, imem_adr, if_valid, if_pc, if_inst} !== model_out()) begin
                errors++;
                $display("FAIL slow_rdy i=%0d: got %h expected %h", i,
                         {imem_req, imem_adr, if_valid, if_pc, if_inst}, model_out());
            end
            if (prev_req && !rdy) begin
                checks++;
                if ({imem_req, imem_adr} !== {1'b1, prev_adr}) begin
                    errors++;
                    $display("FAIL slow_rdy_stable i=%0d: got req=%b adr=%h expected req=1 adr=%h",
                             i, imem_req, imem_adr, prev_adr);
                end
            end
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({if_valid, if_pc} !== {1'b1, 32'h8}) begin
                errors++;
                $display("FAIL freeze_head i=%0d: got v=%b pc=%h expected v=1 pc=00000008", i, if_valid, if_pc);
            end
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL freeze_full_req: got %b expected 0", imem_req);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({if_valid, if_pc} !== {1'b1, 32'(12 + 4*i)}) begin
                errors++;
                $display("FAIL freeze_release i=%0d: got v=%b pc=%h expected v=1 pc=%h",
                         i, if_valid, if_pc, 32'(12 + 4*i));
            end
        end
    endtask

    task automatic test_branch_flush();
        apply_reset();
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (imem_adr !== 32'h10) begin
            errors++;
            $display("FAIL flush_setup: got adr=%h expected 00000010", imem_adr);
        end
        cycle(1'b0, 1'b1, 32'h90, 1'b0);
        checks++;
        if ({imem_req, imem_adr, if_valid} !== {1'b1, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL flush_hold: got req=%b adr=%h v=%b expected req=1 adr=00000010 v=0",
                     imem_req, imem_adr, if_valid);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_req, imem_adr, if_valid} !== {1'b1, 32'h90, 1'b0}) begin
            errors++;
            $display("FAIL flush_redirect: got req=%b adr=%h v=%b expected req=1 adr=00000090 v=0",
                     imem_req, imem_adr, if_valid);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h94, mem_word(32'h90)}) begin
            errors++;
            $display("FAIL flush_target: got v=%b pc=%h inst=%h expected v=1 pc=00000094 inst=%h",
                     if_valid, if_pc, if_inst, mem_word(32'h90));
        end
    endtask

    task automatic test_branch_full();
        logic [31:0] drop0;
        apply_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        drop0 = m_drop;
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        checks++;
        if ({imem_req, imem_adr, if_valid, if_pc} !== {1'b1, 32'h200, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL branch_full: got req=%b adr=%h v=%b pc=%h expected req=1 adr=00000200 v=0 pc=0",
                     imem_req, imem_adr, if_valid, if_pc);
        end
        checks++;
        if (m_drop - drop0 !== 32'd2) begin
            errors++;
            $display("FAIL branch_full_model_drop: got %0d expected 2", m_drop - drop0);
        end
`ifdef IFETCH_STATS_EN
        checks++;
        if (stat_drop_cnt !== 32'd2) begin
            errors++;
            $display("FAIL branch_full_stat_drop: got %0d expected 2", stat_drop_cnt);
        end
`endif
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h204}) begin
            errors++;
            $display("FAIL branch_full_target: got v=%b pc=%h expected v=1 pc=00000204", if_valid, if_pc);
        end
    endtask

    task automatic test_random();
        bit          frz;
        bit          br;
        bit          rdy;
        logic [31:0] bad;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            frz = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            br  = ($urandom_range(0, 19) == 0);
            bad = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) bad = 32'hFFFF_FFF8;
            cycle(frz, br, bad, rdy);
            checks++;
            if ({imem_req, imem_adr, if_valid, if_pc, if_inst} !== model_out()) begin
                errors++;
                $display("FAIL random i=%0d: got %h expected %h", i,
                         {imem_req, imem_adr, if_valid, if_pc, if_inst}, model_out());
            end
`ifdef IFETCH_STATS_EN
            checks++;
            if ({stat_fetch_cnt, stat_drop_cnt} !== {m_fetch, m_drop}) begin
                errors++;
                $display("FAIL random_stats i=%0d: got fetch=%0d drop=%0d expected fetch=%0d drop=%0d",
                         i, stat_fetch_cnt, stat_drop_cnt, m_fetch, m_drop);
            end
`endif
        end
    endtask

    task automatic test_reset_midwait();
        apply_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        imem_rdy     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_adr, if_valid, if_pc, if_inst} !== {RESET_PC, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_midwait: got adr=%h v=%b pc=%h inst=%h expected adr=%h v=0 pc=0 inst=0",
                     imem_adr, if_valid, if_pc, if_inst, RESET_PC);
        end
`ifdef IFETCH_STATS_EN
        checks++;
        if ({stat_fetch_cnt, stat_drop_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_midwait_stats: got fetch=%0d drop=%0d expected 0 0", stat_fetch_cnt, stat_drop_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({imem_req, imem_adr, if_valid, if_pc, if_inst} !== model_out()) begin
                errors++;
                $display("FAIL reset_resume i=%0d: got %h expected %h", i,
                         {imem_req, imem_adr, if_valid, if_pc, if_inst}, model_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_slow_rdy();
        test_freeze();
        test_branch_flush();
        test_branch_full();
        test_random();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifetch_controller.md
# ifetch_controller

Instruction-fetch sequencer between the pipeline's IF stage and the instruction memory. Owns the fetch PC and issues word-aligned read requests over a ready-handshake memory port. Buffers returned instructions in a small prefetch queue and presents them to IF/ID with the PC+4 value the pipeline expects. Handles ID-stage freeze (hazard stall) and EX-stage branch redirect, including discarding responses that are still in flight when a branch occurs.

## Interface
- DEPTH, 2: prefetch queue entries (≥2, power of 2).
- RESET_PC, 32'h0: first fetch address after reset.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall from ID; head entry must not be consumed.
- branch_taken  in  1  redirect request from EX, single-cycle pulse.
- branch_addr  in  32  redirect target, byte address, word aligned.
- imem_req  out  1  read request.
- imem_adr  out  32  byte address of request; bits [1:0] always 0.
- imem_rdy  in  1  memory accepts and returns data this cycle; may be tied 1.
- imem_inst  in  32  read data, valid when imem_req && imem_rdy.
- if_valid  out  1  if_inst/if_pc hold a valid instruction.
- if_inst  out  32  instruction at queue head.
- if_pc  out  32  fetch address of head + 4.

## Operation
- FSM states: FETCH, FLUSH.
- FETCH: imem_req = (count < DEPTH). Handshake completes when imem_req && imem_rdy at a rising edge: push {imem_adr+4, imem_inst}, fetch_pc += 4 (mod 2^32, wraps silently).
- Once imem_req is high, imem_req and imem_adr stay stable until imem_rdy, including during freeze and branch.
- Pop when if_valid && !freeze. Push and pop in the same cycle are allowed at any count; count unchanged.
- branch_taken (priority over freeze and over any push/pop):
  - queue cleared, fetch_pc <= branch_addr.
  - No request outstanding, or imem_rdy high the same cycle: response (if any) dropped; stay FETCH; next request addresses branch_addr.
  - Request outstanding with imem_rdy low: go FLUSH.
- FLUSH: imem_req held high at old address until imem_rdy; that response is dropped, then FETCH. A further branch_taken in FLUSH only updates fetch_pc.
- Queue full: no request; FETCH resumes requests the cycle after a pop frees space.
- if_inst/if_pc show 0 when if_valid is 0.

## Timing
- Reset (async, immediate): fetch_pc = RESET_PC, state FETCH, queue empty, if_valid 0, if_inst 0, if_pc 0, imem_adr RESET_PC. imem_req is combinational and is 1 in the first cycle after release.
- Accept-to-output latency: 1 cycle. Entry pushed at edge N is visible at if_* after edge N.
- With imem_rdy tied 1 and no freeze: one instruction per cycle. First if_valid is 1 cycle after the first request.
- After branch_taken at edge N with no outstanding request: imem_adr = branch_addr from cycle N+1; first target instruction valid at N+2.
- Reset mid-FLUSH or mid-wait abandons the request; no data is retained.

## Configuration
- IFETCH_STATS_EN defined:
  - Adds outputs stat_fetch_cnt (32) and stat_drop_cnt (32), both reset to 0.
  - stat_fetch_cnt increments on every completed handshake.
  - stat_drop_cnt increments per dropped response plus per queue entry discarded by a branch. Both wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package arm_fetch_pkg: state enum (FETCH, FLUSH), ADDR_W = 32, INST_W = 32, PC_STEP = 4, entry struct {pc, inst}.
- Sub-module fetch_queue: DEPTH-entry FIFO with synchronous flush, push/pop/count, registered head. The controller owns the FSM, fetch_pc and handshake.

## Test plan
- rdy tied 1, no freeze, after reset: imem_adr 0,4,8,… on consecutive cycles; if_pc 4,8,12,… with if_valid continuously high from the second cycle.
- imem_rdy asserted every 3rd cycle: imem_req/imem_adr stable while waiting; one valid instruction per 3 cycles, no duplicates.
- freeze for 5 cycles, DEPTH 2: queue fills, imem_req drops, head constant. On release: sequence continues with no gap or repeat.
- branch_taken to 0x90 while a request at 0x10 waits (rdy low 2 cycles): FLUSH; 0x10 data never appears; next imem_adr 0x90; next valid if_pc 0x94.
- branch_taken together with freeze and a full queue: queue cleared, if_valid 0 next cycle, target fetched. With IFETCH_STATS_EN: stat_drop_cnt += 2.
- rst_n low mid-wait: outputs 0 immediately; after release, imem_adr = RESET_PC; stats reset.
